// File: rtl/imem_load_arbiter_if.sv
// imem_load_arbiter_if: fetch, loader and RAM signals shared between the arbiter and its environment
interface imem_load_arbiter_if #(parameter int ADDR_WIDTH = 9);
  logic                  if_req;
  logic [31:0]           if_addr;
  logic                  if_valid;
  logic [31:0]           if_inst;
  logic                  if_err;
  logic                  cpu_hold;
  logic                  ld_start;
  logic                  ld_valid;
  logic [31:0]           ld_data;
  logic                  ld_last;
  logic                  ld_ready;
  logic                  ld_done;
  logic [ADDR_WIDTH:0]   ld_count;
  logic [31:0]           ld_checksum;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;
  modport slave (
    input  if_req, if_addr, ld_start, ld_valid, ld_data, ld_last, ram_rdata,
    output if_valid, if_inst, if_err, cpu_hold, ld_ready, ld_done, ld_count, ld_checksum,
           ram_en, ram_we, ram_addr, ram_wdata
  );
  modport master (
    output if_req, if_addr, ld_start, ld_valid, ld_data, ld_last, ram_rdata,
    input  if_valid, if_inst, if_err, cpu_hold, ld_ready, ld_done, ld_count, ld_checksum,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: shares the instruction RAM between fetch and a program loader.
// Define IMEM_LOAD_CHECKSUM_EN to build the running checksum of loaded words.
module imem_load_arbiter #(
  parameter int          ADDR_WIDTH = 9,
  parameter logic [31:0] BASE_ADDR  = 32'h00400000
) (
  input logic                clk,
  input logic                reset_n,
  imem_load_arbiter_if.slave bus
);
  localparam logic [31:0]           SPAN     = 32'd4 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;
  typedef enum logic [1:0] {RUN, DRAIN, LOAD, DONE} state_t;
  state_t                state_q, state_d;
  logic [31:0]           off;
  logic                  addr_ok, fetch, accept, fin, clr;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  rd_q, valid_q, err_q, hold_q, done_q;
  // Address decode, handshakes, and pointer/counter next values (pointer saturates at the top word)
  always_comb begin
    off     = bus.if_addr - BASE_ADDR;
    addr_ok = off < SPAN && off[1:0] == 2'b00;
    fetch   = state_q == RUN && bus.if_req;
    accept  = state_q == LOAD && bus.ld_valid;
    fin     = accept && (bus.ld_last || ptr_q == LAST_PTR);
    clr     = state_q == RUN && bus.ld_start;
    ptr_d   = clr ? '0 : (accept && ptr_q != LAST_PTR) ? ptr_q + 1'b1 : ptr_q;
    cnt_d   = clr ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
  end
  // Next-state logic: RUN -> DRAIN -> LOAD -> DONE -> RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = bus.ld_start ? DRAIN : RUN;
      DRAIN:   state_d = LOAD;
      LOAD:    state_d = fin ? DONE : LOAD;
      default: state_d = RUN;
    endcase
  end
  // State, pointer and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rd_q    <= fetch && addr_ok;
      valid_q <= fetch;
      err_q   <= fetch && !addr_ok;
      hold_q  <= state_d != RUN;
      done_q  <= state_d == DONE;
    end
  end
  assign bus.ram_en    = (fetch && addr_ok) || accept;
  assign bus.ram_we    = accept;
  assign bus.ram_addr  = state_q == LOAD ? ptr_q : off[ADDR_WIDTH+1:2];
  assign bus.ram_wdata = bus.ld_data;
  assign bus.ld_ready  = state_q == LOAD;
  assign bus.if_valid  = valid_q;
  assign bus.if_inst   = rd_q ? bus.ram_rdata : 32'h0;
  assign bus.if_err    = err_q;
  assign bus.cpu_hold  = hold_q;
  assign bus.ld_done   = done_q;
  assign bus.ld_count  = cnt_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] sum_q;
  // Modulo-2^32 sum of accepted words, cleared when a load starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= clr ? '0 : accept ? sum_q + bus.ld_data : sum_q;
  end
  assign bus.ld_checksum = sum_q;
`else
  assign bus.ld_checksum = '0;
`endif
endmodule

// File: tb/tb_imem_load_arbiter.sv
// tb_imem_load_arbiter: directed and random fetch/load traffic checked against a word-array model
module tb_imem_load_arbiter;
  localparam logic [31:0] BASE = 32'h00400000;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  imem_load_arbiter_if #(.ADDR_WIDTH(9)) bus ();
  imem_load_arbiter #(.ADDR_WIDTH(9), .BASE_ADDR(BASE)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  logic [31:0] mem [512];
  logic        pl_we = 1'b0;
  logic [8:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  // RAM with one-cycle synchronous read and a backdoor preload port
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr];
  end
  logic [31:0] ref_mem [512];
  int          errs = 0;
  int          checks = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_sum = '0;
  function automatic bit in_map(logic [31:0] a);
    return a >= BASE && a < BASE + 32'd2048 && a % 4 == 0;
  endfunction
  function automatic logic [31:0] ref_inst(logic [31:0] a);
    logic [31:0] w;
    w = (a - BASE) / 4;
    return in_map(a) ? ref_mem[w[8:0]] : 32'h0;
  endfunction
  function automatic logic [31:0] exp_ck();
`ifdef IMEM_LOAD_CHECKSUM_EN
    return exp_sum;
`else
    return 32'h0;
`endif
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_cycle(bit req, logic [31:0] a);
    bus.if_req = req;
    bus.if_addr = a;
    #1;
    chk("fetch_ram_en", 32'(bus.ram_en), 32'(req && in_map(a)));
    chk("fetch_ram_we", 32'(bus.ram_we), 32'h0);
    if (req && in_map(a)) chk("fetch_ram_addr", 32'(bus.ram_addr), (a - BASE) / 4);
    tick();
    chk("fetch_valid", 32'(bus.if_valid), 32'(req));
    chk("fetch_hold", 32'(bus.cpu_hold), 32'h0);
    if (req) begin
      chk("fetch_err", 32'(bus.if_err), 32'(!in_map(a)));
      chk("fetch_inst", bus.if_inst, ref_inst(a));
    end
  endtask
  task automatic start_load();
    bus.ld_start = 1'b1;
    bus.if_req = 1'b1;
    bus.if_addr = BASE;
    #1;
    chk("start_ram_en", 32'(bus.ram_en), 32'h1);
    chk("start_ld_ready", 32'(bus.ld_ready), 32'h0);
    tick();
    bus.ld_start = 1'b0;
    chk("drain_hold", 32'(bus.cpu_hold), 32'h1);
    chk("drain_valid", 32'(bus.if_valid), 32'h1);
    chk("drain_inst", bus.if_inst, ref_mem[0]);
    chk("drain_err", 32'(bus.if_err), 32'h0);
    chk("drain_count", 32'(bus.ld_count), 32'h0);
    chk("drain_ck", bus.ld_checksum, 32'h0);
    #1;
    chk("drain_ram_en", 32'(bus.ram_en), 32'h0);
    chk("drain_ld_ready", 32'(bus.ld_ready), 32'h0);
    tick();
    bus.if_req = 1'b0;
    chk("load_hold0", 32'(bus.cpu_hold), 32'h1);
    chk("load_valid0", 32'(bus.if_valid), 32'h0);
    exp_cnt = 0;
    exp_sum = '0;
  endtask
  task automatic load_cycle(bit v, logic [31:0] d, bit last, bit st);
    bus.ld_valid = v;
    bus.ld_data = d;
    bus.ld_last = last;
    bus.ld_start = st;
    bus.if_req = 1'($urandom_range(0, 1));
    bus.if_addr = BASE;
    #1;
    chk("load_ready", 32'(bus.ld_ready), 32'h1);
    chk("load_en", 32'(bus.ram_en), 32'(v));
    chk("load_we", 32'(bus.ram_we), 32'(v));
    if (v) begin
      chk("load_addr", 32'(bus.ram_addr), 32'(exp_cnt));
      chk("load_wdata", bus.ram_wdata, d);
      ref_mem[exp_cnt[8:0]] = d;
      exp_cnt++;
      exp_sum += d;
    end
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last = 1'b0;
    bus.ld_start = 1'b0;
    bus.if_req = 1'b0;
    chk("load_count", 32'(bus.ld_count), 32'(exp_cnt));
    chk("load_ck", bus.ld_checksum, exp_ck());
    chk("load_hold", 32'(bus.cpu_hold), 32'h1);
  endtask
  task automatic finish_load();
    chk("done_pulse", 32'(bus.ld_done), 32'h1);
    chk("done_hold", 32'(bus.cpu_hold), 32'h1);
    bus.ld_valid = 1'b1;
    bus.ld_data = $urandom;
    bus.ld_start = 1'b1;
    #1;
    chk("done_ready", 32'(bus.ld_ready), 32'h0);
    chk("done_ram_en", 32'(bus.ram_en), 32'h0);
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_start = 1'b0;
    chk("post_done", 32'(bus.ld_done), 32'h0);
    chk("post_hold", 32'(bus.cpu_hold), 32'h0);
    chk("post_count", 32'(bus.ld_count), 32'(exp_cnt));
    chk("post_ck", bus.ld_checksum, exp_ck());
    chk("post_valid", 32'(bus.if_valid), 32'h0);
  endtask
  initial begin
    logic [31:0] d, a;
    int r;
    bit fin;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    bus.ld_last = 1'b0;
    for (int i = 0; i < 512; i++) begin
      d = i == 0 ? 32'h24100000 : i == 1 ? 32'h24110000 : i == 2 ? 32'h8E320000 : $urandom;
      ref_mem[i] = d;
      pl_we = 1'b1;
      pl_addr = 9'(i);
      pl_data = d;
      tick();
    end
    pl_we = 1'b0;
    tick();
    chk("rst_hold", 32'(bus.cpu_hold), 32'h0);
    chk("rst_valid", 32'(bus.if_valid), 32'h0);
    chk("rst_inst", bus.if_inst, 32'h0);
    chk("rst_err", 32'(bus.if_err), 32'h0);
    chk("rst_done", 32'(bus.ld_done), 32'h0);
    chk("rst_count", 32'(bus.ld_count), 32'h0);
    chk("rst_ck", bus.ld_checksum, 32'h0);
    chk("rst_ready", 32'(bus.ld_ready), 32'h0);
    chk("rst_ram_en", 32'(bus.ram_en), 32'h0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'h0);
    reset_n = 1'b1;
    tick();
    fetch_cycle(1'b1, BASE);
    fetch_cycle(1'b1, BASE + 32'd4);
    fetch_cycle(1'b1, BASE + 32'd8);
    fetch_cycle(1'b1, BASE + 32'h800);
    fetch_cycle(1'b1, BASE + 32'd2);
    fetch_cycle(1'b1, BASE - 32'd4);
    fetch_cycle(1'b1, BASE + 32'h7FC);
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      a = r < 6 ? BASE + 4 * $urandom_range(0, 511) :
          r == 6 ? BASE - 4 * $urandom_range(1, 16) :
          r == 7 ? BASE + 32'd2048 + 4 * $urandom_range(0, 15) :
          r == 8 ? BASE + 4 * $urandom_range(0, 511) + $urandom_range(1, 3) : $urandom;
      fetch_cycle($urandom_range(0, 3) != 0, a);
    end
    start_load();
    load_cycle(1'b1, 32'h11111111, 1'b0, 1'b0);
    load_cycle(1'b0, 32'hABCDEF01, 1'b0, 1'b0);
    load_cycle(1'b1, 32'h22222222, 1'b0, 1'b1);
    load_cycle(1'b1, 32'h33333333, 1'b1, 1'b0);
    finish_load();
    for (int i = 0; i < 4; i++) fetch_cycle(1'b1, BASE + 4 * i);
    start_load();
    fin = 1'b0;
    for (int k = 0; k < 4000 && !fin; k++) begin
      r = (k >= 2000 || $urandom_range(0, 3) != 0) ? 1 : 0;
      load_cycle(r == 1, $urandom, 1'b0, $urandom_range(0, 15) == 0);
      fin = r == 1 && exp_cnt == 512;
    end
    finish_load();
    fetch_cycle(1'b1, BASE);
    fetch_cycle(1'b1, BASE + 32'h7FC);
    for (int k = 0; k < 20; k++) fetch_cycle(1'b1, BASE + 4 * $urandom_range(0, 511));
    start_load();
    for (int i = 0; i < 5; i++) load_cycle(1'b1, $urandom, 1'b0, 1'b0);
    bus.ld_valid = 1'b1;
    bus.ld_data = 32'hDEADBEEF;
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_hold", 32'(bus.cpu_hold), 32'h0);
    chk("abort_ready", 32'(bus.ld_ready), 32'h0);
    chk("abort_ram_en", 32'(bus.ram_en), 32'h0);
    chk("abort_ram_we", 32'(bus.ram_we), 32'h0);
    chk("abort_count", 32'(bus.ld_count), 32'h0);
    chk("abort_ck", bus.ld_checksum, 32'h0);
    chk("abort_valid", 32'(bus.if_valid), 32'h0);
    chk("abort_done", 32'(bus.ld_done), 32'h0);
    tick();
    tick();
    bus.ld_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("abort_hold_after", 32'(bus.cpu_hold), 32'h0);
    for (int i = 0; i < 6; i++) fetch_cycle(1'b1, BASE + 4 * i);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
